pingpong_bank_ctrl: RTL and testbench
=====================================

# pingpong_bank_ctrl

Ping-pong scheduler for a pair of feature-map buffer banks in the CNN datapath. Drives the 8-bit `select` of the 2:1 write-side demux and the 2:1 read-side mux, so a producer fills one bank while a consumer drains the other. Counts words per frame, generates bank addresses, tracks bank full/empty, and swaps banks at frame boundaries with valid/ready-style flow control on both sides.

## Interface
- `FRAME_LEN`, 784: words per frame per bank; legal range 2..2^ADDR_W.
- `ADDR_W`, 10: bank address width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous clear of all state to reset values.
- `wr_en` input 1: producer presents a word this cycle.
- `wr_ready` output 1: current write bank is empty and accepting.
- `wr_sel` output 8: write-bank select for the demux, value 8'd0 or 8'd1.
- `wr_addr` output ADDR_W: write address within the write bank.
- `rd_en` input 1: consumer takes a word this cycle.
- `rd_valid` output 1: current read bank holds a complete frame.
- `rd_sel` output 8: read-bank select for the mux, value 8'd0 or 8'd1.
- `rd_addr` output ADDR_W: read address within the read bank.
- `rd_last` output 1: current read beat is the final word of the frame.
- `bank_full` output 2: bit n = bank n holds a complete, unread frame.
- `err` output 1: sticky protocol-error flag; see Configuration.

## Operation
- Reset and `flush` values: `wr_sel`=0, `rd_sel`=0, `wr_addr`=0, `rd_addr`=0, `bank_full`=2'b00, `err`=0. Derived outputs are `wr_ready`=1, `rd_valid`=0, `rd_last`=0.
- `flush` takes priority over all other inputs in the same cycle.
- Per-bank state is EMPTY (`bank_full[n]`=0) or FULL (`bank_full[n]`=1).
- `wr_ready` = !bank_full[wr_sel[0]]. `rd_valid` = bank_full[rd_sel[0]]. Both are combinational from registers.
- A write beat is `wr_en && wr_ready`. The beat does `wr_addr++`. When `wr_addr`==FRAME_LEN-1, the beat instead does: `wr_addr`<=0, `bank_full[wr_sel]`<=1, and `wr_sel` toggles.
- A read beat is `rd_en && rd_valid`. The beat does `rd_addr++`. When `rd_addr`==FRAME_LEN-1, the beat instead does: `rd_addr`<=0, `bank_full[rd_sel]`<=0, and `rd_sel` toggles.
- `rd_last` = `rd_valid && rd_addr==FRAME_LEN-1`.
- `wr_en` while `!wr_ready` and `rd_en` while `!rd_valid` are ignored; no state changes.
- Simultaneous write-frame completion and read-frame completion always target different banks, because completion requires opposite `bank_full` states. Both updates apply in the same cycle.
- `wr_sel[7:1]` and `rd_sel[7:1]` are always 0.

## Timing
- All outputs are registered or combinational from registers. There is no combinational path from `wr_en` or `rd_en` to any output.
- Write address and data are sampled by the bank in the same cycle as the beat, so latency is 0. `wr_addr` advances on the next edge.
- Frame completion: `bank_full` set and `wr_sel` swap are visible the cycle after the last write beat. `rd_valid` can rise at the earliest on that same cycle.
- Bank release: `wr_ready` rises the cycle after the final read beat of the bank the writer is waiting on.
- Steady-state throughput is 1 word per cycle per side when both sides are streaming.
- `rst` asserted mid-frame discards both partial frames immediately, asynchronously. `flush` does the same on the next edge.

## Configuration
- Macro `PINGPONG_ERR_EN`.
- Defined: `err` sets to 1 on the cycle after any of the following, and holds until `rst` or `flush`:
  - `wr_en && !wr_ready` (producer overrun);
  - `rd_en && !rd_valid` (consumer underrun).
- Not defined: `err` is tied to 0, and no error-detection logic is synthesized.
- Beat behaviour is identical in both builds.

## Test plan
All scenarios run with FRAME_LEN=4, ADDR_W=2.
- Reset release:
  - After `rst` deasserts: `wr_ready`=1, `rd_valid`=0, `wr_sel`=0, `rd_sel`=0, `bank_full`=00.
- Fill bank 0:
  - Stimulus: 4 consecutive `wr_en` beats.
  - `wr_addr` sequence 0,1,2,3. Next cycle: `bank_full`=01, `wr_sel`=1, `rd_valid`=1, `wr_ready`=1.
- Both full, writer stalls:
  - Stimulus: 4 more writes, then `wr_en` held high.
  - `bank_full`=11 and `wr_ready`=0. `wr_addr` stays 0.
  - With `PINGPONG_ERR_EN`, `err`=1 one cycle later.
- Drain:
  - Stimulus: 4 `rd_en` beats.
  - `rd_addr` sequence 0..3, with `rd_last`=1 on the 4th beat.
  - Next cycle: `bank_full`=10, `rd_sel`=1, `wr_ready`=1.
- Simultaneous completion:
  - Stimulus: writer on its 4th beat into bank 0 in the same cycle as the reader's 4th beat from bank 1.
  - Next cycle: `bank_full`=01, `wr_sel`=1, `rd_sel`=0.
- Mid-frame `flush`:
  - Stimulus: `flush` after 2 write beats.
  - All outputs return to reset values. A following full frame fills bank 0 from address 0.

Source files
------------

// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong bank scheduler: fills one buffer bank while the other drains, swapping at frame ends.
// Zero-latency beats, registered state. Writer stalls on a full bank and reader on an empty one. Optional `PINGPONG_ERR_EN` adds a sticky protocol-error flag.
module pingpong_bank_ctrl #(
    parameter int FRAME_LEN = 784,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    output logic              wr_ready,
    output logic [7:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [7:0]        rd_sel,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic [1:0]        bank_full,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [1:0]        full_q;
    logic [1:0]        full_d;

    logic wr_beat;
    logic rd_beat;
    logic wr_done;
    logic rd_done;

    // Handshake terms depend only on registered state, never on the enables.
    assign wr_ready = !full_q[wr_bank];
    assign rd_valid = full_q[rd_bank];

    assign wr_beat = wr_en && wr_ready;
    assign rd_beat = rd_en && rd_valid;
    assign wr_done = wr_beat && (wr_addr_q == LAST_ADDR);
    assign rd_done = rd_beat && (rd_addr_q == LAST_ADDR);

    // A completing write and a completing read always hit opposite banks.
    always_comb begin
        full_d = full_q;
        if (wr_done) begin
            full_d[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            full_d[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            full_q    <= 2'b00;
        end else if (flush) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            full_q    <= 2'b00;
        end else begin
            full_q <= full_d;
            if (wr_done) begin
                wr_addr_q <= '0;
                wr_bank   <= !wr_bank;
            end else if (wr_beat) begin
                wr_addr_q <= wr_addr_q + ADDR_W'(1);
            end
            if (rd_done) begin
                rd_addr_q <= '0;
                rd_bank   <= !rd_bank;
            end else if (rd_beat) begin
                rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
        end
    end

    assign wr_sel    = {7'd0, wr_bank};
    assign rd_sel    = {7'd0, rd_bank};
    assign wr_addr   = wr_addr_q;
    assign rd_addr   = rd_addr_q;
    assign bank_full = full_q;
    assign rd_last   = rd_valid && (rd_addr_q == LAST_ADDR);

`ifdef PINGPONG_ERR_EN
    logic err_q;

    // Sticky: overrun or underrun attempts are flagged until reset or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (flush) begin
            err_q <= 1'b0;
        end else if ((wr_en && !wr_ready) || (rd_en && !rd_valid)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Directed bench for pingpong_bank_ctrl with a word-count model of the ping-pong schedule.
module tb_pingpong_bank_ctrl;

    localparam int F  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          wr_ready;
    logic [7:0]    wr_sel;
    logic [AW-1:0] wr_addr;
    logic          rd_valid;
    logic [7:0]    rd_sel;
    logic [AW-1:0] rd_addr;
    logic          rd_last;
    logic [1:0]    bank_full;
    logic          err;

    int checks = 0;
    int fails  = 0;

    pingpong_bank_ctrl #(.FRAME_LEN(F), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .rd_en     (rd_en),
        .rd_valid  (rd_valid),
        .rd_sel    (rd_sel),
        .rd_addr   (rd_addr),
        .rd_last   (rd_last),
        .bank_full (bank_full),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Model: total words written/read since reset; banks and addresses follow from frame counts.
    int w_tot = 0;
    int r_tot = 0;
    bit m_err = 1'b0;

    function automatic int m_inflight();
        return (w_tot / F) - (r_tot / F);
    endfunction

    function automatic bit m_wr_ready();
        return m_inflight() < 2;
    endfunction

    function automatic bit m_rd_valid();
        return m_inflight() > 0;
    endfunction

    function automatic logic [1:0] m_bank_full();
        logic [1:0] bf;
        int rf;
        bf = 2'b00;
        rf = r_tot / F;
        if (m_inflight() >= 1) bf[rf % 2] = 1'b1;
        if (m_inflight() >= 2) bf[(rf + 1) % 2] = 1'b1;
        return bf;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit wb;
        bit rb;
        if (rst || flush) begin
            w_tot = 0;
            r_tot = 0;
            m_err = 1'b0;
        end else begin
            wb = wr_en && m_wr_ready();
            rb = rd_en && m_rd_valid();
            if ((wr_en && !wb) || (rd_en && !rb)) m_err = 1'b1;
            if (wb) w_tot++;
            if (rb) r_tot++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_wr_ready",  32'(wr_ready),  32'(m_wr_ready()));
            chk("cmp_rd_valid",  32'(rd_valid),  32'(m_rd_valid()));
            chk("cmp_wr_sel",    32'(wr_sel),    32'((w_tot / F) % 2));
            chk("cmp_rd_sel",    32'(rd_sel),    32'((r_tot / F) % 2));
            chk("cmp_wr_addr",   32'(wr_addr),   32'(w_tot % F));
            chk("cmp_rd_addr",   32'(rd_addr),   32'(r_tot % F));
            chk("cmp_rd_last",   32'(rd_last),   32'(m_rd_valid() && (r_tot % F) == F - 1));
            chk("cmp_bank_full", 32'(bank_full), 32'(m_bank_full()));
`ifdef PINGPONG_ERR_EN
            chk("cmp_err",       32'(err),       32'(m_err));
`else
            chk("cmp_err",       32'(err),       32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;

        // Reset release
        chk("rst_wr_ready",  32'(wr_ready),  32'd1);
        chk("rst_rd_valid",  32'(rd_valid),  32'd0);
        chk("rst_wr_sel",    32'(wr_sel),    32'd0);
        chk("rst_rd_sel",    32'(rd_sel),    32'd0);
        chk("rst_bank_full", 32'(bank_full), 32'd0);

        // Fill bank 0
        for (int i = 0; i < F; i++) begin
            wr_en = 1'b1;
            chk("fill0_wr_addr", 32'(wr_addr), 32'(i));
            tick();
        end
        wr_en = 1'b0;
        chk("fill0_bank_full", 32'(bank_full), 32'd1);
        chk("fill0_wr_sel",    32'(wr_sel),    32'd1);
        chk("fill0_rd_valid",  32'(rd_valid),  32'd1);
        chk("fill0_wr_ready",  32'(wr_ready),  32'd1);

        // Fill bank 1, then keep pushing into a stalled writer
        wr_en = 1'b1;
        repeat (F) tick();
        chk("stall_bank_full", 32'(bank_full), 32'd3);
        chk("stall_wr_ready",  32'(wr_ready),  32'd0);
        chk("stall_wr_addr",   32'(wr_addr),   32'd0);
        tick();
        tick();
        chk("stall_hold_wr_addr",   32'(wr_addr),   32'd0);
        chk("stall_hold_bank_full", 32'(bank_full), 32'd3);
`ifdef PINGPONG_ERR_EN
        chk("stall_err", 32'(err), 32'd1);
`endif
        wr_en = 1'b0;

        // Drain bank 0
        for (int i = 0; i < F; i++) begin
            rd_en = 1'b1;
            chk("drain_rd_addr", 32'(rd_addr), 32'(i));
            chk("drain_rd_last", 32'(rd_last), 32'(i == F - 1));
            tick();
        end
        rd_en = 1'b0;
        chk("drain_bank_full", 32'(bank_full), 32'd2);
        chk("drain_rd_sel",    32'(rd_sel),    32'd1);
        chk("drain_wr_ready",  32'(wr_ready),  32'd1);
        chk("drain_wr_sel",    32'(wr_sel),    32'd0);

        // Simultaneous completion: write bank 0 while reading bank 1
        wr_en = 1'b1;
        rd_en = 1'b1;
        repeat (F) tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("simul_bank_full", 32'(bank_full), 32'd1);
        chk("simul_wr_sel",    32'(wr_sel),    32'd1);
        chk("simul_rd_sel",    32'(rd_sel),    32'd0);

        // Mid-frame flush, with both enables active to exercise priority
        wr_en = 1'b1;
        tick();
        tick();
        chk("flush_pre_wr_addr", 32'(wr_addr), 32'd2);
        flush = 1'b1;
        rd_en = 1'b1;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("flush_wr_sel",    32'(wr_sel),    32'd0);
        chk("flush_rd_sel",    32'(rd_sel),    32'd0);
        chk("flush_wr_addr",   32'(wr_addr),   32'd0);
        chk("flush_rd_addr",   32'(rd_addr),   32'd0);
        chk("flush_bank_full", 32'(bank_full), 32'd0);
        chk("flush_wr_ready",  32'(wr_ready),  32'd1);
        chk("flush_rd_valid",  32'(rd_valid),  32'd0);
        chk("flush_rd_last",   32'(rd_last),   32'd0);
        chk("flush_err",       32'(err),       32'd0);
        for (int i = 0; i < F; i++) begin
            wr_en = 1'b1;
            chk("refill_wr_addr", 32'(wr_addr), 32'(i));
            tick();
        end
        wr_en = 1'b0;
        chk("refill_bank_full", 32'(bank_full), 32'd1);
        chk("refill_wr_sel",    32'(wr_sel),    32'd1);

        // Asynchronous reset in the middle of a frame
        wr_en = 1'b1;
        tick();
        tick();
        wr_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wr_addr",   32'(wr_addr),   32'd0);
        chk("arst_bank_full", 32'(bank_full), 32'd0);
        chk("arst_wr_sel",    32'(wr_sel),    32'd0);
        chk("arst_rd_valid",  32'(rd_valid),  32'd0);
        tick();
        rst = 1'b0;

        // Underrun attempt on an empty bank is ignored
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("underrun_rd_addr", 32'(rd_addr), 32'd0);
`ifdef PINGPONG_ERR_EN
        chk("underrun_err", 32'(err), 32'd1);
`else
        chk("underrun_err", 32'(err), 32'd0);
`endif
        repeat (2) tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
